// File: rtl/rb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rb_pkg
// Description : Shared definitions for the SA result buffer: FSM state
//               encoding and the source/destination select constants.
// Revision    : 1.0 - initial release
// ============================================================================
package rb_pkg;

    // The fourth encoding (2'b11) is unused; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        DRAIN = 2'b10
    } rb_state_t;

    // Values of buf_input_select
    localparam logic SRC_SA     = 1'b0;
    localparam logic SRC_BN     = 1'b1;

    // Values of buf_output_select / latched destination
    localparam logic DST_INPREF = 1'b0;
    localparam logic DST_WPREF  = 1'b1;

endpackage : rb_pkg
`default_nettype wire

// File: rtl/rb_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : rb_fifo_mem
// Description : Row storage for the result buffer. Circular buffer of DEPTH
//               rows with write/read pointers and occupancy count. The head
//               row is read combinationally (first-word fall-through).
// Ports       : clk, rst      - clock, async active-high reset
//               push, wr_data - write strobe and row (ignored when full)
//               pop           - read strobe (ignored when empty)
//               rd_data       - head row
//               full, empty   - occupancy flags
//               count         - number of stored rows
// Revision    : 1.0 - initial release
// ============================================================================
module rb_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_push  = push & ~full;
    assign w_pop   = pop & ~empty;
    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

    // Storage contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : rb_fifo_mem
`default_nettype wire

// File: rtl/sa_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sa_result_buffer
// Description : Captures result rows from the systolic array or batch-norm
//               unit during a training phase, then drains them in write
//               order to the input or weight prefetcher once the controller
//               signals the end of the phase.
// Ports       : clk, rst            - clock, async active-high reset
//               wr_valid            - a row is presented this cycle
//               sa_data, bn_data    - candidate write rows
//               buf_input_select    - 0: sa_data, 1: bn_data (per beat)
//               buf_output_select   - 0: input_pref, 1: weight_pref
//               phase_done          - end-of-phase pulse
//               inpref_ready        - input prefetcher accepts a row
//               wpref_ready         - weight prefetcher accepts a row
//               rd_data             - head row (shared by both destinations)
//               inpref_valid        - head row valid for input_pref
//               wpref_valid         - head row valid for weight_pref
//               fill_count          - current occupancy
//               busy                - not idle
//               drain_done          - one-cycle pulse at end of a drain
//               ovf_err, err_clr    - sticky dropped-write flag and its clear
// Revision    : 1.0 - initial release
// ============================================================================
module sa_result_buffer
    import rb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    input  logic [DATA_W*LANES-1:0] sa_data,
    input  logic [DATA_W*LANES-1:0] bn_data,
    input  logic                    buf_input_select,
    input  logic                    buf_output_select,
    input  logic                    phase_done,
    input  logic                    inpref_ready,
    input  logic                    wpref_ready,
    output logic [DATA_W*LANES-1:0] rd_data,
    output logic                    inpref_valid,
    output logic                    wpref_valid,
    output logic [CNT_W-1:0]        fill_count,
    output logic                    busy,
    output logic                    drain_done,
    output logic                    ovf_err,
    input  logic                    err_clr
);

    localparam int ROW_W = DATA_W * LANES;

    rb_state_t        r_state;
    rb_state_t        w_state_nxt;
    logic             r_dst_sel;
    logic             r_drain_done;
    logic             r_ovf_err;

    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_latch_dst;
    logic             w_drain_done_nxt;
    logic             w_dst_ready;
    logic [ROW_W-1:0] w_wr_row;
    logic [ROW_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_draining;

    rb_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ROW_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .wr_data (w_wr_row),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign w_wr_row    = (buf_input_select == SRC_BN) ? bn_data : sa_data;
    // Only the latched destination's ready can pop; the other is ignored.
    assign w_dst_ready = (r_dst_sel == DST_WPREF) ? wpref_ready : inpref_ready;
    assign w_draining  = (r_state == DRAIN) & ~w_empty;

    // ------------------------------------------------------------------
    // Next-state and strobe logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_push           = 1'b0;
        w_pop            = 1'b0;
        w_drop           = 1'b0;
        w_latch_dst      = 1'b0;
        w_drain_done_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (wr_valid) begin
                    w_push      = 1'b1;
                    w_state_nxt = FILL;
                end
                if (phase_done) begin
                    if (wr_valid) begin
                        // Single-row phase: go straight to draining it.
                        w_latch_dst = 1'b1;
                        w_state_nxt = DRAIN;
                    end else begin
                        // Empty phase: report completion, nothing to drain.
                        w_drain_done_nxt = 1'b1;
                    end
                end
            end

            FILL: begin
                if (wr_valid) begin
                    if (w_full) begin
                        w_drop = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
                if (phase_done) begin
                    w_latch_dst = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end

            DRAIN: begin
                if (wr_valid) begin
                    w_drop = 1'b1;
                end
                if (w_draining && w_dst_ready) begin
                    w_pop = 1'b1;
                    if (w_count == CNT_W'(1)) begin
                        w_state_nxt      = IDLE;
                        w_drain_done_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Destination latch, completion pulse and sticky overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dst_sel    <= DST_INPREF;
            r_drain_done <= 1'b0;
            r_ovf_err    <= 1'b0;
        end else begin
            if (w_latch_dst) begin
                r_dst_sel <= buf_output_select;
            end
            r_drain_done <= w_drain_done_nxt;
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_ovf_err <= 1'b1;
            end else if (err_clr) begin
                r_ovf_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Head row is only exposed while draining so it reads zero otherwise.
    assign rd_data      = (r_state == DRAIN) ? w_head : '0;
    assign inpref_valid = w_draining & (r_dst_sel == DST_INPREF);
    assign wpref_valid  = w_draining & (r_dst_sel == DST_WPREF);
    assign fill_count   = w_count;
    assign busy         = (r_state != IDLE);
    assign drain_done   = r_drain_done;
    assign ovf_err      = r_ovf_err;

endmodule : sa_result_buffer
`default_nettype wire

// File: tb/tb_sa_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sa_result_buffer
// Description : Self-checking bench for sa_result_buffer. A queue-based
//               model of the buffer is compared against the DUT every cycle;
//               directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_result_buffer;

    localparam int DATA_W = 16;
    localparam int LANES  = 4;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int ROW_W  = DATA_W * LANES;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_valid = 1'b0;
    logic [ROW_W-1:0] sa_data = '0;
    logic [ROW_W-1:0] bn_data = '0;
    logic             buf_input_select = 1'b0;
    logic             buf_output_select = 1'b0;
    logic             phase_done = 1'b0;
    logic             inpref_ready = 1'b0;
    logic             wpref_ready = 1'b0;
    logic             err_clr = 1'b0;
    logic [ROW_W-1:0] rd_data;
    logic             inpref_valid;
    logic             wpref_valid;
    logic [CNT_W-1:0] fill_count;
    logic             busy;
    logic             drain_done;
    logic             ovf_err;

    sa_result_buffer #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .wr_valid          (wr_valid),
        .sa_data           (sa_data),
        .bn_data           (bn_data),
        .buf_input_select  (buf_input_select),
        .buf_output_select (buf_output_select),
        .phase_done        (phase_done),
        .inpref_ready      (inpref_ready),
        .wpref_ready       (wpref_ready),
        .rd_data           (rd_data),
        .inpref_valid      (inpref_valid),
        .wpref_valid       (wpref_valid),
        .fill_count        (fill_count),
        .busy              (busy),
        .drain_done        (drain_done),
        .ovf_err           (ovf_err),
        .err_clr           (err_clr)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a queue of stored rows plus a "draining" flag.
    // ------------------------------------------------------------------
    logic [ROW_W-1:0] m_q[$];
    bit               m_drain = 1'b0;
    bit               m_dst   = 1'b0;
    bit               m_ovf   = 1'b0;
    bit               m_dd    = 1'b0;
    bit               m_drop;
    logic [ROW_W-1:0] m_junk;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_drain = 1'b0;
            m_dst   = 1'b0;
            m_ovf   = 1'b0;
            m_dd    = 1'b0;
        end else begin
            m_drop = 1'b0;
            m_dd   = 1'b0;
            if (m_drain) begin
                if (wr_valid) m_drop = 1'b1;
                if (m_q.size() > 0 && (m_dst ? wpref_ready : inpref_ready)) begin
                    m_junk = m_q.pop_front();
                    if (m_q.size() == 0) begin
                        m_drain = 1'b0;
                        m_dd    = 1'b1;
                    end
                end
            end else begin
                if (wr_valid) begin
                    if (m_q.size() == DEPTH) m_drop = 1'b1;
                    else m_q.push_back(buf_input_select ? bn_data : sa_data);
                end
                if (phase_done) begin
                    if (m_q.size() == 0) begin
                        m_dd = 1'b1;
                    end else begin
                        m_drain = 1'b1;
                        m_dst   = buf_output_select;
                    end
                end
            end
            if (m_drop) m_ovf = 1'b1;
            else if (err_clr) m_ovf = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model (outputs depend on state only)
    // ------------------------------------------------------------------
    bit exp_iv, exp_wv;
    always @(negedge clk) begin
        if (rst) begin
            check("rst_inpref_valid", inpref_valid, 0);
            check("rst_wpref_valid", wpref_valid, 0);
            check("rst_fill_count", fill_count, 0);
            check("rst_busy", busy, 0);
            check("rst_drain_done", drain_done, 0);
            check("rst_ovf_err", ovf_err, 0);
            check("rst_rd_data", rd_data, 0);
        end else begin
            exp_iv = m_drain && (m_q.size() > 0) && !m_dst;
            exp_wv = m_drain && (m_q.size() > 0) && m_dst;
            check("inpref_valid", inpref_valid, exp_iv);
            check("wpref_valid", wpref_valid, exp_wv);
            check("fill_count", fill_count, m_q.size());
            check("busy", busy, m_drain || (m_q.size() > 0));
            check("drain_done", drain_done, m_dd);
            check("ovf_err", ovf_err, m_ovf);
            if (exp_iv || exp_wv) check("rd_data", rd_data, m_q[0]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic clear_inputs();
        wr_valid = 1'b0; phase_done = 1'b0; err_clr = 1'b0;
        inpref_ready = 1'b0; wpref_ready = 1'b0;
    endtask

    // Writes n rows; sel_mode 0/1 fixes the source, 2 randomizes per beat.
    // Ends with phase_done either on the last write or one cycle later.
    task automatic fill(input int n, input int sel_mode, input bit pd_on_last,
                        input bit osel, input logic [ROW_W-1:0] base,
                        input bit rnd_data, input bit gaps);
        logic [ROW_W-1:0] row;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    wr_valid = 1'b0; phase_done = 1'b0;
                end
            end
            @(negedge clk);
            wr_valid = 1'b1;
            err_clr  = 1'b0;
            buf_input_select = (sel_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(sel_mode);
            row = rnd_data ? {$urandom(), $urandom()} : base + ROW_W'(i);
            if (buf_input_select) begin
                bn_data = row; sa_data = {$urandom(), $urandom()};
            end else begin
                sa_data = row; bn_data = {$urandom(), $urandom()};
            end
            inpref_ready = 1'($urandom_range(0, 1));
            wpref_ready  = 1'($urandom_range(0, 1));
            phase_done   = pd_on_last && (i == n - 1);
            buf_output_select = phase_done ? osel : 1'($urandom_range(0, 1));
        end
        if (!(pd_on_last && n > 0)) begin
            @(negedge clk);
            wr_valid = 1'b0; phase_done = 1'b1; buf_output_select = osel;
        end
    endtask

    // Drives random readies (and optional noise) until the DUT goes idle.
    task automatic drain_until_idle(input int max_cyc, input bit noise);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            inpref_ready      = 1'($urandom_range(0, 1));
            wpref_ready       = 1'($urandom_range(0, 1));
            buf_output_select = 1'($urandom_range(0, 1));
            wr_valid          = noise && ($urandom_range(0, 7) == 0);
            sa_data           = {$urandom(), $urandom()};
            bn_data           = {$urandom(), $urandom()};
            phase_done        = noise && ($urandom_range(0, 9) == 0);
            err_clr           = noise && ($urandom_range(0, 5) == 0);
        end
        clear_inputs();
        if (!done) check("drain_timeout", 0, 1);
    endtask

    logic [ROW_W-1:0] exp2 [5];
    bit               pat2 [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        clear_inputs();
        @(negedge clk);
        check("lit_reset_rd_data", rd_data, 0);
        check("lit_reset_inpref_valid", inpref_valid, 0);
        check("lit_reset_fill_count", fill_count, 0);
        check("lit_reset_busy", busy, 0);
        #2 rst = 1'b0;

        // ---------------- fill/drain to input_pref ----------------
        fill(4, 0, 1'b0, 1'b0, 64'h1, 1'b0, 1'b0);
        inpref_ready = 1'b1; wpref_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            phase_done = 1'b0;
            check("lit_t1_inpref_valid", inpref_valid, 1);
            check("lit_t1_wpref_valid", wpref_valid, 0);
            check("lit_t1_rd_data", rd_data, 64'(i + 1));
        end
        @(negedge clk);
        check("lit_t1_drain_done", drain_done, 1);
        check("lit_t1_busy", busy, 0);
        check("lit_t1_fill_count", fill_count, 0);
        clear_inputs();
        @(negedge clk);
        check("lit_t1_drain_done_once", drain_done, 0);

        // ---------------- BN to weight_pref with backpressure ----------------
        fill(3, 1, 1'b0, 1'b1, 64'hB0, 1'b0, 1'b0);
        exp2[0] = 64'hB0; exp2[1] = 64'hB1; exp2[2] = 64'hB1; exp2[3] = 64'hB1; exp2[4] = 64'hB2;
        pat2[0] = 1'b1; pat2[1] = 1'b0; pat2[2] = 1'b0; pat2[3] = 1'b1; pat2[4] = 1'b1;
        wpref_ready = 1'b0; inpref_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            phase_done = 1'b0; wr_valid = 1'b0;
            check("lit_t2_wpref_valid", wpref_valid, 1);
            check("lit_t2_inpref_valid", inpref_valid, 0);
            check("lit_t2_rd_data", rd_data, exp2[k]);
            wpref_ready = pat2[k];
            inpref_ready = 1'b1;
        end
        @(negedge clk);
        check("lit_t2_drain_done", drain_done, 1);
        check("lit_t2_busy", busy, 0);
        clear_inputs();

        // ---------------- overflow ----------------
        fill(18, 0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("lit_t3_fill_count_sat", fill_count, 16);
        check("lit_t3_ovf_err", ovf_err, 1);
        drain_until_idle(200, 1'b0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("lit_t3_ovf_cleared", ovf_err, 0);

        // ---------------- wrap-around, back-to-back phases ----------------
        fill(12, 2, 1'b0, 1'($urandom_range(0, 1)), '0, 1'b1, 1'b0);
        drain_until_idle(200, 1'b0);
        fill(12, 2, 1'b1, 1'($urandom_range(0, 1)), '0, 1'b1, 1'b0);
        @(negedge clk);
        clear_inputs();
        check("lit_t4_twelfth_row_kept", fill_count, 12);
        check("lit_t4_busy", busy, 1);
        drain_until_idle(200, 1'b0);

        // ---------------- empty phase ----------------
        @(negedge clk);
        phase_done = 1'b1;
        @(negedge clk);
        phase_done = 1'b0;
        check("lit_t5_empty_drain_done", drain_done, 1);
        check("lit_t5_empty_no_valid", inpref_valid | wpref_valid, 0);
        @(negedge clk);
        check("lit_t5_empty_pulse_once", drain_done, 0);

        // ---------------- reset mid-drain ----------------
        fill(6, 0, 1'b0, 1'b0, 64'h60, 1'b0, 1'b0);
        @(negedge clk);
        phase_done = 1'b0; inpref_ready = 1'b1;
        @(negedge clk);
        inpref_ready = 1'b0;
        check("lit_t6_count_before_rst", fill_count, 5);
        #2;
        clear_inputs();
        rst = 1'b1;
        #1;
        check("lit_t6_rst_inpref_valid", inpref_valid, 0);
        check("lit_t6_rst_fill_count", fill_count, 0);
        check("lit_t6_rst_busy", busy, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("lit_t6_no_drain_done", drain_done, 0);

        // ---------------- randomized phases ----------------
        for (int p = 0; p < 40; p++) begin
            fill($urandom_range(0, 20), 2, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), '0, 1'b1, 1'b1);
            drain_until_idle(300, 1'b1);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sa_result_buffer
`default_nettype wire

// File: doc/sa_result_buffer.md
Name: sa_result_buffer

Overview:
- Responder to the training-phase controller: captures result rows during FP/BP/WG, then drains them to the input prefetcher or weight prefetcher.
- Write source is chosen per beat by buf_input_select: 0 selects the systolic array (SA) output, 1 selects the batch-norm (BN) output.
- Drain destination is chosen by buf_output_select: 0 selects input_pref, 1 selects weight_pref. It is latched when the phase ends.
- Sits between the SA/BN outputs and the two prefetchers. The controller's complete pulse (phase_done) turns it from filling to draining.

Parameters:
- DATA_W, 16, width of one lane.
- LANES, 4, lanes per row. The row width is DATA_W*LANES.
- DEPTH, 16, row entries. Must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_valid  in  1  one result row is presented this cycle.
- sa_data  in  DATA_W*LANES  SA result row.
- bn_data  in  DATA_W*LANES  BN result row.
- buf_input_select  in  1  0 selects sa_data, 1 selects bn_data. Sampled on every write beat.
- buf_output_select  in  1  0 drains to input_pref, 1 drains to weight_pref.
- phase_done  in  1  one-cycle pulse from the controller at the end of a phase.
- inpref_ready  in  1  input prefetcher accepts a row.
- wpref_ready  in  1  weight prefetcher accepts a row.
- rd_data  out  DATA_W*LANES  head row, shared by both destinations.
- inpref_valid  out  1  rd_data is valid for input_pref.
- wpref_valid  out  1  rd_data is valid for weight_pref.
- fill_count  out  CNT_W  current occupancy.
- busy  out  1  high whenever the state is not IDLE.
- drain_done  out  1  one-cycle pulse when a drain completes.
- ovf_err  out  1  sticky flag: a write was dropped.
- err_clr  in  1  synchronous clear of ovf_err.

Behaviour:
- Reset (async, while rst=1):
  - state = IDLE; write and read pointers = 0; fill_count = 0; dst_sel = 0.
  - All outputs 0; rd_data = 0.
  - Storage contents are don't-care.
  - Asserting rst mid-fill or mid-drain discards all data. No drain_done is pulsed.
- State IDLE:
  - wr_valid=1: the beat is written this cycle, fill_count becomes 1, next state FILL.
  - phase_done=1 with no write: drain_done pulses next cycle, state stays IDLE (empty phase).
  - phase_done=1 together with a write: the write is taken, dst_sel is latched, next state DRAIN.
- State FILL:
  - Each wr_valid=1 beat writes the selected row at the write pointer.
  - The write pointer advances modulo DEPTH and fill_count increments.
  - When full (fill_count==DEPTH), a write is dropped, the count is unchanged and ovf_err is set.
  - phase_done=1: dst_sel <= buf_output_select and next state DRAIN. A write in the same cycle is still accepted, subject to the full rule.
  - Changes to buf_output_select after that point are ignored until the next phase.
- State DRAIN:
  - rd_data = storage[read pointer], first-word fall-through with no extra latency.
  - Valids: inpref_valid = (fill_count!=0) & ~dst_sel; wpref_valid = (fill_count!=0) & dst_sel.
  - A pop occurs on valid & ready of the selected destination. The ready of the non-selected destination is ignored.
  - Each pop advances the read pointer modulo DEPTH and decrements fill_count.
  - When the pop that makes fill_count 0 occurs: next state IDLE and drain_done=1 for exactly that next cycle.
  - Valid stays asserted while ready is low. rd_data must hold stable until the pop.
  - wr_valid in DRAIN: the beat is dropped and ovf_err is set.
  - phase_done in DRAIN is ignored.
- Latency:
  - A row written in cycle N can appear on rd_data no earlier than cycle N+1, and only in DRAIN.
  - Maximum throughput is one pop per cycle.
- ovf_err:
  - Set on any dropped write.
  - err_clr=1 clears it. If a drop and err_clr occur in the same cycle, set wins.
- busy = (state != IDLE).
- Ordering: rows drain strictly in write order across pointer wrap-around.

Decomposition:
- Shared package rb_pkg holds:
  - state encoding: IDLE=2'b00, FILL=2'b01, DRAIN=2'b10; the unused encoding 2'b11 returns to IDLE;
  - the select constants SRC_SA=0, SRC_BN=1, DST_INPREF=0, DST_WPREF=1.
- One sub-module, rb_fifo_mem:
  - DEPTH x (DATA_W*LANES) storage with pointers and count;
  - push and pop strobes, full/empty flags, combinational head read.
- The top level holds the FSM, source mux, destination latch, valid steering and error flag.

Test Plan:
- Fill and drain to input_pref:
  - Stimulus: buf_input_select=0, write 4 SA rows 0x1..0x4; phase_done with buf_output_select=0; inpref_ready=1.
  - Required: inpref_valid high for 4 cycles with rd_data 0x1, 0x2, 0x3, 0x4; wpref_valid stays 0; drain_done pulses once; fill_count returns to 0; busy falls.
- BN source to weight_pref with backpressure:
  - Stimulus: buf_input_select=1, 3 BN rows; buf_output_select=1; wpref_ready toggles 1,0,0,1,1.
  - Required: rows pop only on ready=1; rd_data holds while ready=0; inpref_ready is ignored.
- Overflow with DEPTH=16:
  - Stimulus: 18 write beats.
  - Required: fill_count saturates at 16; ovf_err=1; the drain outputs exactly the first 16 rows in order.
  - Then err_clr: ovf_err=0.
- Wrap-around and simultaneous events:
  - Stimulus: run two back-to-back phases of 12 rows; the second phase_done coincides with its last write.
  - Required: the 12th row is included; order is correct across the pointer wrap.
- Empty phase and reset mid-drain:
  - Empty phase: phase_done in IDLE gives a drain_done pulse and no valids.
  - Reset mid-drain: rst asserted mid-drain immediately drops valids, fill_count=0, state IDLE, no drain_done.
